// File: rtl/sidebuf_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : sidebuf_sched_if
// Description : Handshake bundle between the side-buffer scheduler and its
//               surrounding router logic.
//               Inputs to the scheduler:
//                 buf_req     - deflected flit present, store it
//                 slot_free   - injection slot available this cycle
//                 local_req   - local PE wants the injection slot
//               Outputs from the scheduler:
//                 wr_en       - one-hot bank write enable (combinational)
//                 rd_sel      - head entry index (registered)
//                 reinj_grant - head flit takes the slot (combinational)
//                 local_grant - local flit takes the slot (combinational)
//                 count       - occupancy 0..DEPTH (registered)
//                 full/empty  - occupancy flags
//                 redirect    - starvation redirect request (registered)
//                 overflow    - sticky dropped-write flag
//               Modport master belongs to the router side and slave to the
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface sidebuf_sched_if #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
);
    logic             buf_req;
    logic             slot_free;
    logic             local_req;
    logic [DEPTH-1:0] wr_en;
    logic [PTR_W-1:0] rd_sel;
    logic             reinj_grant;
    logic             local_grant;
    logic [PTR_W:0]   count;
    logic             full;
    logic             empty;
    logic             redirect;
    logic             overflow;

    modport master (
        output buf_req, slot_free, local_req,
        input  wr_en, rd_sel, reinj_grant, local_grant,
        input  count, full, empty, redirect, overflow
    );

    modport slave (
        input  buf_req, slot_free, local_req,
        output wr_en, rd_sel, reinj_grant, local_grant,
        output count, full, empty, redirect, overflow
    );
endinterface
`default_nettype wire

// File: rtl/sidebuf_sched.sv
`default_nettype none
// ============================================================================
// Module      : sidebuf_sched
// Description : Control and scheduling for a DEPTH-entry circular side
//               buffer of flit registers (no data path here). Produces the
//               one-hot write enables and head read select for the bank,
//               arbitrates the single injection slot between buffer
//               re-injection and local PE injection (round-robin on
//               contention), and raises a redirect request when buffered
//               flits have been denied for STARVE_LIM consecutive cycles.
//               Ports:
//                 clk   - clock, rising edge
//                 reset - synchronous, active-high
//                 bus   - sidebuf_sched_if.slave handshake bundle
// Revision    : 1.0 - initial release
// ============================================================================
module sidebuf_sched #(
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2,
    parameter int STARVE_LIM = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sidebuf_sched_if.slave    bus
);

    localparam logic [PTR_W:0]   c_full_count = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_count_one  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);
    localparam logic [7:0]       c_starve_lim = 8'(STARVE_LIM);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
    logic [PTR_W:0]   count_q,      count_d;
    logic             rr_last_q,    rr_last_d;
    logic [7:0]       starve_cnt_q, starve_cnt_d;
    logic             redirect_q,   redirect_d;
    logic             overflow_q,   overflow_d;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic             w_full;
    logic             w_empty;
    logic             w_contention;
    logic             w_buf_wins;
    logic             w_reinj_grant;
    logic             w_local_grant;
    logic             w_pop;
    logic             w_write;
    logic             w_drop;
    logic [DEPTH-1:0] w_wr_en;

    assign w_full  = (count_q == c_full_count);
    assign w_empty = (count_q == '0);

    always_comb begin
        w_contention  = 1'b0;
        w_buf_wins    = 1'b0;
        w_reinj_grant = 1'b0;
        w_local_grant = 1'b0;
        w_pop         = 1'b0;
        w_write       = 1'b0;
        w_drop        = 1'b0;
        w_wr_en       = '0;

        // Only flits already resident (registered count) are eligible,
        // so a flit written this cycle cannot bypass to the slot.
        w_contention = bus.slot_free & ~w_empty & bus.local_req;
        // A full buffer or a pending redirect overrides round-robin so the
        // buffer cannot be starved indefinitely.
        w_buf_wins   = w_full | redirect_q | rr_last_q;

        if (bus.slot_free) begin
            if (w_empty) begin
                w_local_grant = bus.local_req;
            end else if (!bus.local_req) begin
                w_reinj_grant = 1'b1;
            end else if (w_buf_wins) begin
                w_reinj_grant = 1'b1;
            end else begin
                w_local_grant = 1'b1;
            end
        end

        w_pop   = w_reinj_grant;
        // A pop frees the head entry in the same cycle, so a full buffer
        // can still accept a write when it is popping.
        w_write = bus.buf_req & (~w_full | w_pop);
        w_drop  = bus.buf_req & w_full & ~w_pop;

        if (w_write) begin
            w_wr_en[wr_ptr_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rr_last_d    = rr_last_q;
        starve_cnt_d = starve_cnt_q;
        redirect_d   = 1'b0;
        overflow_d   = overflow_q;

        if (w_write) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end

        case ({w_write, w_pop})
            2'b10:   count_d = count_q + c_count_one;
            2'b01:   count_d = count_q - c_count_one;
            default: count_d = count_q;
        endcase

        // rr_last: 0 = buffer won the last contention, 1 = local won.
        if (w_contention) begin
            rr_last_d = ~w_buf_wins;
        end

        if (w_empty || w_pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != c_starve_lim) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end

        // Registering the compare of the next count gives redirect in the
        // same cycle that the counter reaches the limit.
        redirect_d = (starve_cnt_d == c_starve_lim);

        if (w_drop) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rr_last_q    <= 1'b0;
            starve_cnt_q <= '0;
            redirect_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rr_last_q    <= rr_last_d;
            starve_cnt_q <= starve_cnt_d;
            redirect_q   <= redirect_d;
            overflow_q   <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wr_en       = w_wr_en;
    assign bus.rd_sel      = rd_ptr_q;
    assign bus.reinj_grant = w_reinj_grant;
    assign bus.local_grant = w_local_grant;
    assign bus.count       = count_q;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.redirect    = redirect_q;
    assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sidebuf_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_sidebuf_sched
// Description : Directed self-checking bench for sidebuf_sched with
//               DEPTH=4 and STARVE_LIM=3. Each scenario task drives inputs
//               shortly after a rising edge and checks outputs mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sidebuf_sched;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    sidebuf_sched_if #(.DEPTH(4), .PTR_W(2)) bus ();

    sidebuf_sched #(
        .DEPTH      (4),
        .PTR_W      (2),
        .STARVE_LIM (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic b, input logic s, input logic l);
        bus.buf_req   = b;
        bus.slot_free = s;
        bus.local_req = l;
        #1;
    endtask

    task automatic do_reset;
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.rd_sel !== 2'd0) begin errors++; $display("FAIL reset_rd_sel: got %0d want 0", bus.rd_sel); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", bus.redirect); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        checks++; if ({bus.wr_en, bus.reinj_grant, bus.local_grant} !== 6'b0) begin
            errors++; $display("FAIL reset_comb: got wr_en=%b rg=%b lg=%b want all 0", bus.wr_en, bus.reinj_grant, bus.local_grant);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fill_drain;
        logic [3:0] exp_wr;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            exp_wr = 4'b0001 << i;
            checks++; if (bus.wr_en !== exp_wr) begin errors++; $display("FAIL fill_wr_en[%0d]: got %b want %b", i, bus.wr_en, exp_wr); end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d want 4", bus.count); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            checks++; if (bus.reinj_grant !== 1'b1 || bus.local_grant !== 1'b0) begin
                errors++; $display("FAIL drain_grant[%0d]: got rg=%b lg=%b want rg=1 lg=0", i, bus.reinj_grant, bus.local_grant);
            end
            checks++; if (bus.rd_sel !== 2'(i)) begin errors++; $display("FAIL drain_rd_sel[%0d]: got %0d want %0d", i, bus.rd_sel, i); end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin
            errors++; $display("FAIL drain_empty: got empty=%b count=%0d want 1/0", bus.empty, bus.count);
        end
        // An empty buffer hands the slot straight to the local PE.
        drive(1'b0, 1'b1, 1'b1);
        checks++; if (bus.local_grant !== 1'b1 || bus.reinj_grant !== 1'b0) begin
            errors++; $display("FAIL empty_local_grant: got lg=%b rg=%b want lg=1 rg=0", bus.local_grant, bus.reinj_grant);
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    task automatic test_overflow;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        // Write while full with no pop is dropped.
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (bus.wr_en !== 4'b0000) begin errors++; $display("FAIL ovf_wr_en: got %b want 0000", bus.wr_en); end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", bus.count); end
        // Full write + pop: both allowed, count stays at 4.
        drive(1'b1, 1'b1, 1'b0);
        checks++; if (bus.reinj_grant !== 1'b1) begin errors++; $display("FAIL fwp_grant: got %b want 1", bus.reinj_grant); end
        checks++; if (bus.wr_en !== 4'b0001) begin errors++; $display("FAIL fwp_wr_en: got %b want 0001", bus.wr_en); end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fwp_count: got %0d want 4", bus.count); end
        checks++; if (bus.rd_sel !== 2'd1) begin errors++; $display("FAIL fwp_rd_sel: got %0d want 1", bus.rd_sel); end
        // Drain; head starts at entry 1 and wraps.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            checks++; if (bus.rd_sel !== 2'((i + 1) % 4)) begin
                errors++; $display("FAIL ovf_drain_rd_sel[%0d]: got %0d want %0d", i, bus.rd_sel, (i + 1) % 4);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty: got %b want 1", bus.empty); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
        // Write pointer advanced past entry 0 during the full write+pop.
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (bus.wr_en !== 4'b0010) begin errors++; $display("FAIL fwp_wr_ptr: got %b want 0010", bus.wr_en); end
        drive(1'b0, 1'b0, 1'b0);
        do_reset();
        #1;
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset_clear: got %b want 0", bus.overflow); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin;
        logic [3:0] exp_local;
        exp_local = 4'b0101;   // bit i: 1 = local wins in contention cycle i
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            checks++; if (bus.local_grant !== exp_local[i] || bus.reinj_grant !== ~exp_local[i]) begin
                errors++; $display("FAIL rr_winner[%0d]: got lg=%b rg=%b want lg=%b rg=%b", i,
                                   bus.local_grant, bus.reinj_grant, exp_local[i], ~exp_local[i]);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rr_empty: got %b want 1", bus.empty); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_starvation;
        logic exp_redir;
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        // Cycles 1..6 with count=1 and the slot held off.
        for (int k = 1; k <= 6; k++) begin
            drive(1'b0, 1'b0, 1'b1);
            exp_redir = (k >= 4);
            checks++; if (bus.redirect !== exp_redir) begin
                errors++; $display("FAIL starve_redirect[c%0d]: got %b want %b", k, bus.redirect, exp_redir);
            end
            if (k == 2) begin
                checks++; if (bus.local_grant !== 1'b0 || bus.reinj_grant !== 1'b0) begin
                    errors++; $display("FAIL starve_no_slot: got lg=%b rg=%b want 0/0", bus.local_grant, bus.reinj_grant);
                end
            end
            tick();
        end
        // rr_last is 0, so only the redirect lets the buffer win here.
        drive(1'b0, 1'b1, 1'b1);
        checks++; if (bus.reinj_grant !== 1'b1 || bus.local_grant !== 1'b0) begin
            errors++; $display("FAIL starve_force: got rg=%b lg=%b want rg=1 lg=0", bus.reinj_grant, bus.local_grant);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL starve_release: got %b want 0", bus.redirect); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL starve_empty: got %b want 1", bus.empty); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid;
        do_reset();
        drive(1'b1, 1'b0, 1'b0);     // count 0 -> 1
        tick();
        drive(1'b1, 1'b1, 1'b0);     // write + pop, count stays 1
        tick();
        drive(1'b1, 1'b0, 1'b0);     // 1 -> 2
        tick();
        drive(1'b1, 1'b0, 1'b0);     // 2 -> 3
        tick();
        drive(1'b0, 1'b0, 1'b0);     // hold, starve counter reaches 3
        tick();
        checks++; if (bus.count !== 3'd3 || bus.redirect !== 1'b1 || bus.rd_sel !== 2'd1) begin
            errors++; $display("FAIL mid_setup: got count=%0d redirect=%b rd_sel=%0d want 3/1/1", bus.count, bus.redirect, bus.rd_sel);
        end
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", bus.count); end
        checks++; if (bus.rd_sel !== 2'd0) begin errors++; $display("FAIL mid_rd_sel: got %0d want 0", bus.rd_sel); end
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL mid_redirect: got %b want 0", bus.redirect); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b want 1", bus.empty); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b want 0", bus.overflow); end
        drive(1'b1, 1'b0, 1'b0);
        checks++; if (bus.wr_en !== 4'b0001) begin errors++; $display("FAIL mid_wr_ptr: got %b want 0001", bus.wr_en); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.buf_req   = 1'b0;
        bus.slot_free = 1'b0;
        bus.local_req = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_round_robin();
        test_starvation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sidebuf_sched.md
# sidebuf_sched

Control/scheduling block for the router's side buffer: a DEPTH-entry circular bank of enable-gated flit registers, with no data path inside this block. It generates one-hot write enables and the read select for that bank. It arbitrates the single injection slot between re-injection from the buffer and local PE injection. It raises a starvation redirect request when buffered flits wait too long.

## Interface
- DEPTH, 4: number of side-buffer entries; power of two, ≥2.
- PTR_W, 2: log2(DEPTH).
- STARVE_LIM, 8: consecutive denied cycles before redirect asserts; range 1..255.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- buf_req  in  1  deflected flit present this cycle; buffer it.
- slot_free  in  1  injection slot available this cycle.
- local_req  in  1  local PE requests injection.
- wr_en  out  DEPTH  one-hot enable to the register at wr_ptr; combinational.
- rd_sel  out  PTR_W  index of the head entry (rd_ptr); registered.
- reinj_grant  out  1  head flit takes the slot this cycle; combinational.
- local_grant  out  1  local flit takes the slot this cycle; combinational.
- count  out  PTR_W+1  occupancy 0..DEPTH; registered.
- full / empty  out  1  count==DEPTH / count==0.
- redirect  out  1  starvation redirect request; registered.
- overflow  out  1  sticky error: write dropped while full.

## Operation
- **State registers**
  - wr_ptr, rd_ptr: PTR_W bits; wrap modulo DEPTH.
  - count.
  - rr_last: 0 = buffer won the last contention, 1 = local won.
  - starve_cnt: 8-bit.
  - overflow.
- **Reset values:** all state 0. Outputs after reset: rd_sel=0, count=0, empty=1, full=0, redirect=0, overflow=0. Combinational outputs are 0 while inputs are 0.
- **Arbitration** (combinational; all grants 0 when slot_free=0):
  - empty, or buffer not eligible: local_grant = local_req.
  - !empty and !local_req: reinj_grant=1.
  - !empty and local_req (contention): buffer wins if full | redirect | (rr_last==1); otherwise local wins.
  - reinj_grant and local_grant are never both 1.
- **Pop:** pop = reinj_grant. On pop, rd_ptr increments.
- **Write:** wr_en[wr_ptr] = buf_req & (!full | pop), so a write into a full buffer is allowed when a pop happens in the same cycle. On write, wr_ptr increments.
- **Dropped write:** buf_req & full & !pop. wr_en=0 and overflow is set; overflow clears only on reset.
- **count update:** +1 on write without pop, −1 on pop without write, unchanged on both or neither.
- **rr_last:** updates only on contention cycles, to 0 if the buffer won and 1 if local won.
- **Starvation counter:**
  - cleared when empty or on reinj_grant.
  - otherwise increments each cycle, saturating at STARVE_LIM.
  - redirect = (starve_cnt == STARVE_LIM), registered. Once asserted it forces the buffer to win the next contention.

## Timing
- Grants and wr_en respond to the current-cycle inputs with zero latency. count, rd_sel, full, empty and redirect reflect the write/pop on the following cycle.
- A flit written in cycle N is eligible for re-injection from cycle N+1; there is no same-cycle bypass.
- Simultaneous write and pop when count=DEPTH: count stays DEPTH and both pointers advance.
- Simultaneous write and pop when count=0 cannot occur, because pop requires !empty.
- Reset asserted mid-operation: all state returns to its reset value on that clock edge. Grants in the reset cycle are still computed from current state and inputs, and the downstream logic ignores them.
- Redirect asserts exactly STARVE_LIM cycles after the first denied non-empty cycle, counting from a cleared starve_cnt. It deasserts in the cycle after the pop.

## Test plan
- **Fill/drain:** reset, buf_req=1 for 4 cycles with slot_free=0 → wr_en = 0001, 0010, 0100, 1000; count=4, full=1. Then slot_free=1, local_req=0 for 4 cycles → reinj_grant=1 each cycle, rd_sel = 0, 1, 2, 3; empty=1 at the end.
- **Overflow:** with the buffer full, buf_req=1, slot_free=0 → wr_en=0, overflow=1 next cycle, count stays 4. overflow remains 1 after the drain until reset.
- **Full write+pop:** count=4, buf_req=1, slot_free=1 → reinj_grant=1, wr_en[wr_ptr]=1, count stays 4, both pointers advance by 1.
- **Round-robin:** count=2, local_req=1, slot_free=1 for 4 cycles, buf_req=0 → the winner alternates, starting with local (rr_last=0 after reset): local, buffer, local, buffer.
- **Starvation:**
  - Setup: STARVE_LIM=3, count=1, slot_free=0 held.
  - redirect=1 after 3 cycles; starve_cnt saturates.
  - Then slot_free=1, local_req=1 → reinj_grant=1, and redirect=0 on the next cycle.
- **Reset mid-run:** count=3 and redirect=1, assert reset for 1 cycle → count=0, rd_sel=0, redirect=0, empty=1, overflow=0 on the next cycle.
